// File: rtl/vector_accumulate_seq.sv
// Packet accumulator around an external registered adder tree: accepted beats go out on
// tree_vector, per-beat sums return TREE_LATENCY cycles later and are folded into packet totals.
module vector_accumulate_seq #(
   parameter int vector_length = 7,
   parameter int data_width    = 48,
   parameter int TREE_LATENCY  = 3,
   parameter int OUT_DEPTH     = 2,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [vector_length*data_width-1:0] in_vector,
   input  logic                                in_valid,
   input  logic                                in_last,
   output logic                                in_ready,
   output logic [vector_length*data_width-1:0] tree_vector,
   input  logic [data_width-1:0]               tree_sum,
   output logic [data_width-1:0]               out_sum,
   output logic [CNT_WIDTH-1:0]                out_beats,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                overflow
);

   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CRD_W = PTR_W + 2;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
   endfunction

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                  state, state_nxt;
   logic [data_width-1:0]   acc, acc_nxt;
   logic [CNT_WIDTH-1:0]    beats, beats_nxt;
   logic                    ovf_set;
   logic                    push, pop;
   logic [data_width-1:0]   push_sum;
   logic [CNT_WIDTH-1:0]    push_beats;

   logic                    accept;
   logic [TREE_LATENCY:0]   tag_vld_p, tag_last_p;
   logic                    tag_vld, tag_last;
   logic [PTR_W:0]          last_cnt;

   logic [data_width+CNT_WIDTH-1:0] mem [OUT_DEPTH];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [PTR_W:0]          fifo_count;

   assign accept   = in_valid & in_ready;
   assign tag_vld  = tag_vld_p[TREE_LATENCY];
   assign tag_last = tag_last_p[TREE_LATENCY];

   // A credit is held from a last-beat accept until its packet lands in the FIFO
   assign in_ready = (CRD_W'(fifo_count) + CRD_W'(last_cnt)) < CRD_W'(OUT_DEPTH);

   // Stage 0: capture the accepted beat for the tree and launch its tag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tree_vector <= '0;
         tag_vld_p   <= '0;
         tag_last_p  <= '0;
      end else begin
         if (accept) tree_vector <= in_vector;
         tag_vld_p[0]  <= accept;
         tag_last_p[0] <= accept & in_last;
         for (int i = 1; i <= TREE_LATENCY; i++) begin
            tag_vld_p[i]  <= tag_vld_p[i-1];
            tag_last_p[i] <= tag_last_p[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_cnt <= '0;
      end else begin
         case ({accept & in_last, tag_vld & tag_last})
            2'b10:   last_cnt <= last_cnt + 1'b1;
            2'b01:   last_cnt <= last_cnt - 1'b1;
            default: last_cnt <= last_cnt;
         endcase
      end
   end

   // Stage TREE_LATENCY+1: fold the aligned tree sum into the open packet
   always_comb begin
      state_nxt  = state;
      acc_nxt    = acc;
      beats_nxt  = beats;
      ovf_set    = 1'b0;
      push       = 1'b0;
      push_sum   = '0;
      push_beats = '0;
      if (tag_vld) begin
         case (state)
            IDLE: begin
               if (tag_last) begin
                  push       = 1'b1;
                  push_sum   = tree_sum;
                  push_beats = CNT_WIDTH'(1);
               end else begin
                  acc_nxt   = tree_sum;
                  beats_nxt = CNT_WIDTH'(1);
                  state_nxt = ACCUM;
               end
            end
            ACCUM: begin
               ovf_set = (beats == CNT_MAX);
               if (tag_last) begin
                  push       = 1'b1;
                  push_sum   = acc + tree_sum;
                  push_beats = sat_inc(beats);
                  acc_nxt    = '0;
                  beats_nxt  = '0;
                  state_nxt  = IDLE;
               end else begin
                  acc_nxt   = acc + tree_sum;
                  beats_nxt = sat_inc(beats);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         acc      <= '0;
         beats    <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         beats <= beats_nxt;
         if (ovf_set) overflow <= 1'b1;
      end
   end

   // Result FIFO, first-word fall-through; storage needs no reset since out_valid gates it
   assign pop       = out_valid & out_ready;
   assign out_valid = (fifo_count != '0);
   assign {out_sum, out_beats} = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {push_sum, push_beats};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_accumulate_seq.sv
// Bench for vector_accumulate_seq: behavioural adder tree, scoreboard of expected packet
// results, plus a second instance with a 2-bit beat counter for saturation behaviour.
module tb_vector_accumulate_seq;

   localparam int VL = 7;
   localparam int DW = 48;
   localparam int TL = 3;
   localparam int OD = 2;
   localparam int CW = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [VL*DW-1:0] in_vector;
   logic             in_valid, in_last, out_ready;
   logic             in_ready, in_ready2;
   logic [VL*DW-1:0] tree_vector, tree_vector2;
   logic [DW-1:0]    tree_sum, tree_sum2, out_sum, out_sum2;
   logic [CW-1:0]    out_beats;
   logic [1:0]       out_beats2;
   logic             out_valid, out_valid2, overflow, overflow2;

   typedef struct {
      logic [DW-1:0] sum;
      logic [CW-1:0] beats;
   } res_t;

   res_t          sb[$];
   res_t          mon_e;
   logic [DW-1:0] pkt_sum = '0;
   int            pkt_beats = 0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vector_accumulate_seq #(.vector_length(VL), .data_width(DW), .TREE_LATENCY(TL),
                           .OUT_DEPTH(OD), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .in_vector(in_vector), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .tree_vector(tree_vector),
      .tree_sum(tree_sum), .out_sum(out_sum), .out_beats(out_beats),
      .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow));

   vector_accumulate_seq #(.vector_length(VL), .data_width(DW), .TREE_LATENCY(TL),
                           .OUT_DEPTH(OD), .CNT_WIDTH(2)) dut_sat (
      .clk(clk), .reset(reset), .in_vector(in_vector), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready2), .tree_vector(tree_vector2),
      .tree_sum(tree_sum2), .out_sum(out_sum2), .out_beats(out_beats2),
      .out_valid(out_valid2), .out_ready(out_ready), .overflow(overflow2));

   function automatic logic [DW-1:0] lane_sum(input logic [VL*DW-1:0] v);
      logic [DW-1:0] s;
      s = '0;
      for (int i = 0; i < VL; i++) s = s + v[i*DW +: DW];
      return s;
   endfunction

   function automatic logic [VL*DW-1:0] make_vec(input logic [DW-1:0] base, input int step);
      logic [VL*DW-1:0] v;
      for (int i = 0; i < VL; i++) v[i*DW +: DW] = base + DW'(i * step);
      return v;
   endfunction

   function automatic logic [VL*DW-1:0] rand_vec();
      logic [VL*DW-1:0] v;
      for (int i = 0; i < VL; i++) v[i*DW +: DW] = {16'($urandom), 32'($urandom)};
      return v;
   endfunction

   // Behavioural registered adder tree: TL register stages from tree_vector to tree_sum
   logic [DW-1:0] tr1 [TL];
   logic [DW-1:0] tr2 [TL];
   always @(posedge clk) begin
      tr1[0] <= lane_sum(tree_vector);
      tr2[0] <= lane_sum(tree_vector2);
      for (int i = 1; i < TL; i++) begin
         tr1[i] <= tr1[i-1];
         tr2[i] <= tr2[i-1];
      end
   end
   assign tree_sum  = tr1[TL-1];
   assign tree_sum2 = tr2[TL-1];

   // Every pop is checked against the oldest expected packet result
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_result: got sum=%0d beats=%0d, required no result", out_sum, out_beats);
         end else begin
            mon_e = sb.pop_front();
            if (out_sum !== mon_e.sum || out_beats !== mon_e.beats) begin
               n_bad++;
               $display("FAIL scoreboard: got sum=%0d beats=%0d, required sum=%0d beats=%0d",
                        out_sum, out_beats, mon_e.sum, mon_e.beats);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      sb.delete();
      pkt_sum   = '0;
      pkt_beats = 0;
      step(1);
   endtask

   task automatic send_beat(input logic [VL*DW-1:0] v, input logic last, output int acc_edge);
      int n;
      n = 0;
      in_vector = v;
      in_valid  = 1'b1;
      in_last   = last;
      while (!in_ready && n < 100) begin
         step(1);
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
      end
      step(1);
      acc_edge = cyc;
      pkt_sum = pkt_sum + lane_sum(v);
      if (pkt_beats < (1 << CW) - 1) pkt_beats++;
      if (last) begin
         res_t r;
         r.sum   = pkt_sum;
         r.beats = CW'(pkt_beats);
         sb.push_back(r);
         pkt_sum   = '0;
         pkt_beats = 0;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out_valid(output int n);
      n = 0;
      while (!out_valid && n < 30) begin
         step(1);
         n++;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_vector = '0;
      out_ready = 1'b0;
      step(2);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
      n_cmp++; if (out_sum !== '0) begin n_bad++; $display("FAIL reset_out_sum: got %0d, required 0", out_sum); end
      n_cmp++; if (out_beats !== '0) begin n_bad++; $display("FAIL reset_out_beats: got %0d, required 0", out_beats); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
      n_cmp++; if (overflow !== 1'b0 || overflow2 !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %0b/%0b, required 0/0", overflow, overflow2); end
      n_cmp++; if (tree_vector !== '0) begin n_bad++; $display("FAIL reset_tree_vector: got %0h, required 0", tree_vector); end
      reset = 1'b0;
      step(1);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %0b, required 1", in_ready); end
   endtask

   task automatic test_basic();
      int a, n, lat;
      logic [VL*DW-1:0] v;
      v = make_vec(DW'(1), 1);
      out_ready = 1'b1;
      send_beat(v, 1'b0, a);
      n_cmp++; if (tree_vector !== v) begin n_bad++; $display("FAIL tree_vector_capture: got %0h, required %0h", tree_vector, v); end
      send_beat(v, 1'b0, a);
      send_beat(v, 1'b1, a);
      wait_out_valid(n);
      lat = cyc - a;
      // Accept cycle ends at edge a; out_valid is due in the cycle starting at edge a+TL+1
      n_cmp++; if (lat !== TL + 1) begin n_bad++; $display("FAIL basic_latency: got %0d edges, required %0d", lat, TL + 1); end
      n_cmp++; if (out_sum !== 48'd84 || out_beats !== 16'd3) begin n_bad++; $display("FAIL basic_result: got sum=%0d beats=%0d, required sum=84 beats=3", out_sum, out_beats); end
      step(3);
   endtask

   task automatic test_wrap();
      int a, n;
      out_ready = 1'b1;
      send_beat(make_vec('1, 0), 1'b1, a);
      wait_out_valid(n);
      n_cmp++; if (out_sum !== 48'hFFFF_FFFF_FFF9 || out_beats !== 16'd1) begin n_bad++; $display("FAIL wrap_result: got sum=%0h beats=%0d, required sum=fffffffffff9 beats=1", out_sum, out_beats); end
      step(3);
   endtask

   task automatic test_backpressure();
      int a, b, c;
      logic [VL*DW-1:0] va, vb, vc;
      va = make_vec(DW'(10), 1);
      vb = make_vec(DW'(100), 0);
      vc = make_vec(DW'(7), 3);
      out_ready = 1'b0;
      send_beat(va, 1'b1, a);
      send_beat(vb, 1'b1, b);
      n_cmp++; if (b !== a + 1) begin n_bad++; $display("FAIL bp_back_to_back: got gap %0d, required 1", b - a); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_drop: got in_ready=%0b, required 0", in_ready); end
      in_vector = vc;
      in_valid  = 1'b1;
      in_last   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_%0d: got in_ready=%0b, required 0", i, in_ready); end
      end
      n_cmp++; if (out_valid !== 1'b1 || out_sum !== lane_sum(va)) begin n_bad++; $display("FAIL bp_head: got valid=%0b sum=%0d, required valid=1 sum=%0d", out_valid, out_sum, lane_sum(va)); end
      n_cmp++; if (tree_vector !== vb) begin n_bad++; $display("FAIL bp_not_accepted: got %0h, required %0h", tree_vector, vb); end
      out_ready = 1'b1;
      send_beat(vc, 1'b1, c);
      step(12);
      n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL bp_drain: got %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_push_pop();
      int a, b, n;
      logic [VL*DW-1:0] v1, v2;
      v1 = rand_vec();
      v2 = rand_vec();
      out_ready = 1'b0;
      send_beat(v1, 1'b1, a);
      wait_out_valid(n);
      send_beat(v2, 1'b1, b);
      step(TL);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_sum !== lane_sum(v2) || out_beats !== 16'd1) begin n_bad++; $display("FAIL pushpop_head: got valid=%0b sum=%0h beats=%0d, required valid=1 sum=%0h beats=1", out_valid, out_sum, out_beats, lane_sum(v2)); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL pushpop_count: got in_ready=%0b, required 1", in_ready); end
      out_ready = 1'b1;
      step(2);
      n_cmp++; if (out_valid !== 1'b0 || sb.size() !== 0) begin n_bad++; $display("FAIL pushpop_drain: got valid=%0b pending=%0d, required 0/0", out_valid, sb.size()); end
   endtask

   task automatic test_back_to_back();
      int e0, e;
      out_ready = 1'b1;
      send_beat(rand_vec(), 1'b0, e0);
      send_beat(rand_vec(), 1'b0, e);
      send_beat(rand_vec(), 1'b0, e);
      send_beat(rand_vec(), 1'b1, e);
      send_beat(rand_vec(), 1'b0, e);
      send_beat(rand_vec(), 1'b1, e);
      n_cmp++; if (e - e0 !== 5) begin n_bad++; $display("FAIL b2b_throughput: got %0d edges for 6 beats, required 5", e - e0); end
      step(10);
      n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_reset_mid();
      int a, n;
      out_ready = 1'b1;
      send_beat(make_vec(DW'(9), 1), 1'b0, a);
      step(2);
      reset = 1'b1;
      #1;
      n_cmp++; if (tree_vector !== '0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL async_reset: got tree_vector=%0h in_ready=%0b, required 0/1", tree_vector, in_ready); end
      step(2);
      reset = 1'b0;
      pkt_sum   = '0;
      pkt_beats = 0;
      step(1);
      send_beat(make_vec(DW'(5), 0), 1'b1, a);
      wait_out_valid(n);
      n_cmp++; if (out_sum !== 48'd35 || out_beats !== 16'd1) begin n_bad++; $display("FAIL reset_mid_result: got sum=%0d beats=%0d, required sum=35 beats=1", out_sum, out_beats); end
      step(6);
      n_cmp++; if (sb.size() !== 0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mid_drain: got pending=%0d valid=%0b, required 0/0", sb.size(), out_valid); end
   endtask

   task automatic test_overflow();
      int a, n;
      out_ready = 1'b1;
      pulse_reset();
      n_cmp++; if (overflow2 !== 1'b0) begin n_bad++; $display("FAIL ovf_cleared_start: got %0b, required 0", overflow2); end
      for (int i = 0; i < 4; i++) send_beat(make_vec(DW'(1), 0), (i == 3), a);
      n = 0;
      while (!out_valid2 && n < 30) begin
         step(1);
         n++;
      end
      n_cmp++; if (out_beats2 !== 2'd3 || out_sum2 !== 48'd28) begin n_bad++; $display("FAIL ovf_sat_result: got sum=%0d beats=%0d, required sum=28 beats=3", out_sum2, out_beats2); end
      n_cmp++; if (overflow2 !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0b, required 1", overflow2); end
      n_cmp++; if (overflow !== 1'b0 || out_beats !== 16'd4) begin n_bad++; $display("FAIL ovf_wide: got overflow=%0b beats=%0d, required 0/4", overflow, out_beats); end
      step(3);
      send_beat(make_vec(DW'(2), 0), 1'b1, a);
      step(8);
      n_cmp++; if (overflow2 !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %0b, required 1", overflow2); end
      pulse_reset();
      n_cmp++; if (overflow2 !== 1'b0) begin n_bad++; $display("FAIL ovf_reset_clear: got %0b, required 0", overflow2); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_push_pop();
      test_back_to_back();
      test_reset_mid();
      test_overflow();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
